// File: rtl/hub75_pkg.sv
// hub75_pkg
//   Definitions shared by the HUB75 plane reader and its output FIFO.
//   - CH_R/CH_G/CH_B : channel slot, used both as the BITDEPTH-wide field
//                      index inside a pixel word and as the bit offset
//                      inside each word's 3-bit group of px_data.
//   - N_CH           : channels per pixel.
//   - state_e        : sweep controller state encoding.
package hub75_pkg;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;
  localparam int unsigned N_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/hub75_skid_fifo.sv
// hub75_skid_fifo
//   Two-entry FIFO with registered storage. The output word is selected
//   straight from the storage registers, so it does not change while the
//   head entry waits to be popped. Reset empties the FIFO and zeroes its
//   contents.
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   push_i   in   write data_i this cycle (caller guarantees room)
//   pop_i    in   drop head entry this cycle (caller guarantees not empty)
//   data_i   in   WIDTH  word to store
//   data_o   out  WIDTH  head entry
//   empty_o  out  no entries held
//   count_o  out  2      number of entries held (0..2)
module hub75_skid_fifo #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // When full, a simultaneous push lands in the slot being popped; the read
  // pointer has already moved on to the older remaining entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/hub75_plane_reader.sv
// hub75_plane_reader
//   On an accepted ctrl_go, sweeps every column of one line-buffer bank,
//   extracts bit-plane P of the R, G and B channel of each pixel word and
//   streams 3*N_WORDS bits per column to the HUB75 column shifter through a
//   valid/ready handshake. ctrl_done pulses the cycle after the final
//   column's handshake.
// Optional build macro
//   HUB75_PLANE_READER_REVERSE_EN : adds cfg_reverse; when captured high the
//   sweep runs from column N_COLS-1 down to 0 and px_last marks column 0.
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   ctrl_go     in   start a sweep (only taken when ctrl_rdy is high)
//   ctrl_bank   in   bank to sweep, captured with go
//   ctrl_plane  in   bit-plane index, captured with go
//   cfg_reverse in   descending sweep, captured with go (macro builds only)
//   ctrl_rdy    out  idle and able to accept go
//   ctrl_done   out  one-cycle end-of-sweep pulse
//   lb_rd_addr  out  {bank, column} line-buffer read address
//   lb_rd_ena   out  read strobe; lb_rd_data valid the following cycle
//   lb_rd_data  in   N_WORDS packed words, word w = {B, G, R}
//   px_data     out  bit 3w+0/1/2 = R/G/B of word w at the selected plane
//   px_last     out  marks the final column of the sweep
//   px_valid    out  output handshake valid
//   px_ready    in   output handshake ready
module hub75_plane_reader
  import hub75_pkg::*;
#(
  parameter int unsigned N_WORDS    = 2,
  parameter int unsigned BITDEPTH   = 8,
  parameter int unsigned LOG_N_COLS = 6,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ctrl_go,
  input  logic                              ctrl_bank,
  input  logic [$clog2(BITDEPTH)-1:0]       ctrl_plane,
`ifdef HUB75_PLANE_READER_REVERSE_EN
  input  logic                              cfg_reverse,
`endif
  output logic                              ctrl_rdy,
  output logic                              ctrl_done,
  output logic [ADDR_WIDTH-1:0]             lb_rd_addr,
  output logic                              lb_rd_ena,
  input  logic [N_WORDS*3*BITDEPTH-1:0]     lb_rd_data,
  output logic [3*N_WORDS-1:0]              px_data,
  output logic                              px_last,
  output logic                              px_valid,
  input  logic                              px_ready
);

  localparam int unsigned WORD_WIDTH = N_CH * BITDEPTH;
  localparam int unsigned PX_W       = N_CH * N_WORDS;
  localparam int unsigned PLANE_W    = $clog2(BITDEPTH);

  state_e                  state_q;
  state_e                  state_d;
  logic                    bank_q;
  logic [PLANE_W-1:0]      plane_q;
  logic [LOG_N_COLS-1:0]   col_q;
  logic                    inflight_q;
  logic                    inflightLast_q;
  logic                    done_q;
  logic                    doneD;

  logic                    rev;
  logic [LOG_N_COLS-1:0]   startCol;
  logic [LOG_N_COLS-1:0]   endCol;
  logic                    goAccept;
  logic                    pop;
  logic                    lastIssue;
  logic [2:0]              occupancy;
  logic [1:0]              fifoCount;
  logic                    fifoEmpty;
  logic [PX_W-1:0]         pxBits;

`ifdef HUB75_PLANE_READER_REVERSE_EN
  logic rev_q;

  // Direction is frozen for the whole sweep, like bank and plane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_q <= 1'b0;
    end else if (goAccept) begin
      rev_q <= cfg_reverse;
    end
  end

  assign rev      = rev_q;
  assign startCol = cfg_reverse ? '1 : '0;
`else
  assign rev      = 1'b0;
  assign startCol = '0;
`endif

  assign endCol   = rev ? '0 : '1;
  assign ctrl_rdy = (state_q == ST_IDLE) && !done_q;
  assign goAccept = ctrl_go && ctrl_rdy;
  assign pop      = px_valid && px_ready;

  // A read is only issued if the word it returns is guaranteed a FIFO slot:
  // entries held plus the word already in flight, less the one leaving now.
  always_comb begin
    occupancy = 3'(fifoCount) + 3'(inflight_q) - 3'(pop);
    lb_rd_ena = (state_q == ST_RUN) && (occupancy < 3'd2);
    lastIssue = lb_rd_ena && (col_q == endCol);
  end

  assign lb_rd_addr = {bank_q, col_q};

  // Sweep sequencing; DRAIN waits for the last column to leave the FIFO.
  always_comb begin
    state_d = state_q;
    doneD   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (goAccept) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (lastIssue) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && px_last) begin
          state_d = ST_IDLE;
          doneD   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The column counter holds at the end column instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bank_q         <= 1'b0;
      plane_q        <= '0;
      col_q          <= '0;
      inflight_q     <= 1'b0;
      inflightLast_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      inflight_q     <= lb_rd_ena;
      inflightLast_q <= lastIssue;
      done_q         <= doneD;
      if (goAccept) begin
        bank_q  <= ctrl_bank;
        plane_q <= ctrl_plane;
        col_q   <= startCol;
      end else if (lb_rd_ena && !lastIssue) begin
        col_q <= rev ? (col_q - 1'b1) : (col_q + 1'b1);
      end
    end
  end

  assign ctrl_done = done_q;

  // Pick bit plane_q of each channel field of each returned word.
  always_comb begin
    pxBits = '0;
    for (int w = 0; w < int'(N_WORDS); w++) begin
      pxBits[w*N_CH + CH_R] = lb_rd_data[w*WORD_WIDTH + CH_R*BITDEPTH + int'(plane_q)];
      pxBits[w*N_CH + CH_G] = lb_rd_data[w*WORD_WIDTH + CH_G*BITDEPTH + int'(plane_q)];
      pxBits[w*N_CH + CH_B] = lb_rd_data[w*WORD_WIDTH + CH_B*BITDEPTH + int'(plane_q)];
    end
  end

  hub75_skid_fifo #(
    .WIDTH (PX_W + 1)
  ) uFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .data_i  ({inflightLast_q, pxBits}),
    .data_o  ({px_last, px_data}),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign px_valid = !fifoEmpty;

endmodule

// File: tb/tb_hub75_plane_reader.sv
// tb_hub75_plane_reader
//   Scoreboard bench for hub75_plane_reader. Each sweep request pushes the
//   64 expected {px_last, px_data} words; a negedge monitor pops and compares
//   on every handshake, checks read addresses, output hold under
//   backpressure and the done pulse.
module tb_hub75_plane_reader;

  localparam int N_COLS = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_go;
  logic        ctrl_bank;
  logic [2:0]  ctrl_plane;
  logic        ctrl_rdy;
  logic        ctrl_done;
  logic [6:0]  lb_rd_addr;
  logic        lb_rd_ena;
  logic [47:0] lb_rd_data;
  logic [5:0]  px_data;
  logic        px_last;
  logic        px_valid;
  logic        px_ready;
`ifdef HUB75_PLANE_READER_REVERSE_EN
  logic        cfgReverse = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          doneCount = 0;
  int          doneCycle = 0;
  int          popCount = 0;
  bit          randomReady = 1'b0;
  logic [6:0]  expQ [$];
  logic        expBank = 1'b0;
  logic [5:0]  expCol = '0;
  bit          stallPrev = 1'b0;
  logic [6:0]  heldVal = '0;
  logic [47:0] lbMem [128];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  hub75_plane_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_go    (ctrl_go),
    .ctrl_bank  (ctrl_bank),
    .ctrl_plane (ctrl_plane),
`ifdef HUB75_PLANE_READER_REVERSE_EN
    .cfg_reverse(cfgReverse),
`endif
    .ctrl_rdy   (ctrl_rdy),
    .ctrl_done  (ctrl_done),
    .lb_rd_addr (lb_rd_addr),
    .lb_rd_ena  (lb_rd_ena),
    .lb_rd_data (lb_rd_data),
    .px_data    (px_data),
    .px_last    (px_last),
    .px_valid   (px_valid),
    .px_ready   (px_ready)
  );

  // Pixel word content: word = {B, G, R}.
  function automatic logic [23:0] pix(input logic bank, input int w, input int col);
    logic [7:0] c;
    c = 8'(col);
    if (bank) return {8'hA5, ~c, c};
    if (w == 0) return {c, 8'h0F, ~c};
    return {8'h33, c, 8'hC3};
  endfunction

  function automatic logic [5:0] expPx(input logic bank, input logic [2:0] plane, input int col);
    logic [5:0]  r;
    logic [23:0] p;
    r = '0;
    for (int w = 0; w < 2; w++) begin
      p = pix(bank, w, col);
      r[3*w+0] = p[int'(plane)];
      r[3*w+1] = p[8 + int'(plane)];
      r[3*w+2] = p[16 + int'(plane)];
    end
    return r;
  endfunction

  // Line buffer model: one-cycle registered read.
  always @(posedge clk) begin
    if (lb_rd_ena) lb_rd_data <= lbMem[lb_rd_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ctrl_rdy"}, 32'(ctrl_rdy), 1);
    checkOutput({tag, " ctrl_done"}, 32'(ctrl_done), 0);
    checkOutput({tag, " lb_rd_ena"}, 32'(lb_rd_ena), 0);
    checkOutput({tag, " lb_rd_addr"}, 32'(lb_rd_addr), 0);
    checkOutput({tag, " px_valid"}, 32'(px_valid), 0);
    checkOutput({tag, " px_last"}, 32'(px_last), 0);
    checkOutput({tag, " px_data"}, 32'(px_data), 0);
  endtask

  // Ready driver: held high, or ~30% duty when randomReady is set.
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready = randomReady ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stallPrev) begin
        checkOutput("hold valid", 32'(px_valid), 1);
        checkOutput("hold data", 32'({px_last, px_data}), 32'(heldVal));
      end
      if (px_valid && px_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected px", 32'({px_last, px_data}), 32'hFFFF_FFFF);
        end else begin
          checkOutput("px", 32'({px_last, px_data}), 32'(expQ.pop_front()));
        end
        popCount++;
      end
      stallPrev = px_valid && !px_ready;
      heldVal   = {px_last, px_data};
      if (lb_rd_ena) begin
        checkOutput("rd addr", 32'(lb_rd_addr), 32'({expBank, expCol}));
        expCol++;
      end
      if (ctrl_done) begin
        doneCount++;
        doneCycle = cycleCnt;
        checkOutput("rdy during done", 32'(ctrl_rdy), 0);
      end
    end else begin
      stallPrev = 1'b0;
    end
  end

  // Issue one sweep, then wait (bounded) for its done pulse.
  task automatic applyStimulus(input logic bank, input logic [2:0] plane,
                               input bit pulseGo, input bit checkLatency);
    int w;
    int doneBefore;
    int goCycle;
    w = 0;
    while (!ctrl_rdy && w < 200) begin
      @(posedge clk); #1; w++;
    end
    checkOutput("rdy before go", 32'(ctrl_rdy), 1);
    for (int c = 0; c < N_COLS; c++) expQ.push_back({c == N_COLS - 1, expPx(bank, plane, c)});
    expBank    = bank;
    expCol     = '0;
    doneBefore = doneCount;
    @(posedge clk); #1;
    ctrl_go    = 1'b1;
    ctrl_bank  = bank;
    ctrl_plane = plane;
    goCycle    = cycleCnt;
    @(posedge clk); #1;
    ctrl_go    = 1'b0;
    ctrl_bank  = ~bank;
    ctrl_plane = plane + 3'd3;
    checkOutput("rd_ena cycle1", 32'(lb_rd_ena), 1);
    checkOutput("rdy in run", 32'(ctrl_rdy), 0);
    @(posedge clk); #1;
    checkOutput("valid cycle2", 32'(px_valid), 0);
    @(posedge clk); #1;
    checkOutput("valid cycle3", 32'(px_valid), 1);
    if (pulseGo) begin
      repeat (2) @(posedge clk);
      #1;
      ctrl_go = 1'b1;
      checkOutput("rdy at go pulse 5", 32'(ctrl_rdy), 0);
      @(posedge clk); #1;
      ctrl_go = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      ctrl_go = 1'b1;
      checkOutput("rdy at go pulse 20", 32'(ctrl_rdy), 0);
      @(posedge clk); #1;
      ctrl_go = 1'b0;
    end
    w = 0;
    while (doneCount == doneBefore && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    checkOutput("done seen", 32'(doneCount != doneBefore), 1);
    if (checkLatency) checkOutput("go-to-done cycles", 32'(doneCycle - goCycle), 67);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("single done", 32'(doneCount - doneBefore), 1);
    checkOutput("scoreboard empty", 32'(expQ.size()), 0);
    checkOutput("rdy after done", 32'(ctrl_rdy), 1);
  endtask

  // Start a sweep, assert reset around column 30, then run a clean sweep.
  task automatic applyResetMidSweep();
    int w;
    int popBefore;
    int doneBefore;
    for (int c = 0; c < N_COLS; c++) expQ.push_back({c == N_COLS - 1, expPx(1'b1, 3'd0, c)});
    expBank   = 1'b1;
    expCol    = '0;
    popBefore = popCount;
    @(posedge clk); #1;
    ctrl_go    = 1'b1;
    ctrl_bank  = 1'b1;
    ctrl_plane = 3'd0;
    @(posedge clk); #1;
    ctrl_go = 1'b0;
    w = 0;
    while ((popCount - popBefore) < 30 && w < 500) begin
      @(posedge clk); #1; w++;
    end
    checkOutput("reached col 30", 32'(popCount - popBefore >= 30), 1);
    doneBefore = doneCount;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("mid-sweep reset");
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no done after reset", 32'(doneCount - doneBefore), 0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int a = 0; a < 128; a++) begin
      lbMem[a] = {pix(a[6], 1, a % 64), pix(a[6], 0, a % 64)};
    end
    lb_rd_data = '0;
    rst_n      = 1'b0;
    ctrl_go    = 1'b0;
    ctrl_bank  = 1'b0;
    ctrl_plane = 3'd0;
    #2;
    checkResetOutputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] bank1 plane0, ready held");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
    $display("[TB] bank1 plane7, extra go pulses");
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b1);
    randomReady = 1'b1;
    $display("[TB] bank0 plane2, random ready");
    applyStimulus(1'b0, 3'd2, 1'b0, 1'b0);
    $display("[TB] bank1 plane3, random ready");
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    randomReady = 1'b0;
    $display("[TB] reset mid-sweep");
    applyResetMidSweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
